ardu_link_receiver: RTL



---
 rtl/ardu_link_pkg.sv | 11 +
 rtl/ardu_link_sync.sv | 25 ++
 rtl/ardu_link_receiver.sv | 111 +++++++++++
 3 files changed

// File: rtl/ardu_link_pkg.sv
// ardu_link_pkg: shared widths, special codes and FSM encoding for the digit link receiver
package ardu_link_pkg;
   localparam int CODE_W = 4;
   localparam int SYM_W  = 3;
   localparam logic [CODE_W-1:0] CODE_CLEAR = 4'd14;
   localparam logic [CODE_W-1:0] CODE_END   = 4'd15;
   typedef enum logic {WAIT_HI = 1'b0, WAIT_LO = 1'b1} state_t;
   function automatic logic is_digit(input logic [CODE_W-1:0] c);
      return c < 4'd10;
   endfunction
endpackage

// File: rtl/ardu_link_sync.sv
// ardu_link_sync: multi-flop synchroniser for the link lines plus strobe rising-edge detect
module ardu_link_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       hwclk,
   input  logic       resetN,
   input  logic [3:0] lines,
   output logic [2:0] sym,
   output logic       sym_stb
);
   logic [3:0] sync_q [SYNC_STAGES];
   logic       stb_prev;
   // shift the raw lines through the synchroniser chain and remember the last synced strobe
   always_ff @(posedge hwclk or negedge resetN)
      if (!resetN) begin
         sync_q   <= '{default: '0};
         stb_prev <= 1'b0;
      end else begin
         sync_q[0] <= lines;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         stb_prev <= sync_q[SYNC_STAGES-1][3];
      end
   assign sym     = sync_q[SYNC_STAGES-1][2:0];
   assign sym_stb = sync_q[SYNC_STAGES-1][3] & ~stb_prev;
endmodule

// File: rtl/ardu_link_receiver.sv
// ardu_link_receiver: reassembles 4-bit codes from symbol pairs and accumulates decimal numbers
module ardu_link_receiver
   import ardu_link_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1200000,
   parameter int MAX_DIGITS     = 10,
   parameter int SYNC_STAGES    = 2
) (
   input  logic              hwclk,
   input  logic              resetN,
   input  logic              in0,
   input  logic              in1,
   input  logic              in2,
   input  logic              inControl,
   output logic [CODE_W-1:0] code,
   output logic              code_valid,
   output logic [31:0]       number,
   output logic              number_valid,
   output logic              num_err,
   output logic              frame_err,
   output logic              busy
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DW = $clog2(MAX_DIGITS + 2);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [DW-1:0] D_MAX  = DW'(MAX_DIGITS);

   state_t             state, state_nxt;
   logic [SYM_W-1:0]   sym;
   logic               sym_stb;
   logic               hi_bit;
   logic [TW-1:0]      tcnt;
   logic [31:0]        acc;
   logic [DW-1:0]      dcnt;
   logic               ovf;

   ardu_link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .hwclk  (hwclk),
      .resetN (resetN),
      .lines  ({inControl, in2, in1, in0}),
      .sym    (sym),
      .sym_stb(sym_stb)
   );

   wire              hi_ok    = (state == WAIT_HI) && sym_stb && (sym[2:1] == 2'b00);
   wire              hi_bad   = (state == WAIT_HI) && sym_stb && (sym[2:1] != 2'b00);
   wire              lo_edge  = (state == WAIT_LO) && sym_stb;
   wire              timeout  = (state == WAIT_LO) && !sym_stb && (tcnt == T_LAST);
   wire [CODE_W-1:0] new_code = {hi_bit, sym};
   wire [35:0]       prod     = {4'd0, acc} * 36'd10 + {32'd0, new_code};
   wire [DW-1:0]     dcnt_inc = dcnt + 1'b1;
   wire              dig_ovf  = (prod > 36'hFFFF_FFFF) || (dcnt_inc > D_MAX);

   // state register
   always_ff @(posedge hwclk or negedge resetN)
      if (!resetN) state <= WAIT_HI;
      else state <= state_nxt;

   // next state: a good high symbol opens a code, a low edge or timeout closes it (edge wins)
   always_comb begin
      state_nxt = (state == WAIT_HI) ? (hi_ok ? WAIT_LO : WAIT_HI)
                                     : ((sym_stb || timeout) ? WAIT_HI : WAIT_LO);
   end

   // busy while a high symbol awaits its low partner
   always_comb begin
      busy = (state == WAIT_LO);
   end

   // code assembly, timeout counting, digit accumulation and commit on END
   always_ff @(posedge hwclk or negedge resetN)
      if (!resetN) begin
         code         <= '0;
         code_valid   <= 1'b0;
         number       <= '0;
         number_valid <= 1'b0;
         num_err      <= 1'b0;
         frame_err    <= 1'b0;
         hi_bit       <= 1'b0;
         tcnt         <= '0;
         acc          <= '0;
         dcnt         <= '0;
         ovf          <= 1'b0;
      end else begin
         code_valid   <= lo_edge;
         number_valid <= lo_edge && (new_code == CODE_END);
         frame_err    <= hi_bad || timeout;
         tcnt         <= ((state == WAIT_LO) && !sym_stb) ? tcnt + 1'b1 : '0;
         if (hi_ok) hi_bit <= sym[0];
         if (lo_edge) begin
            code <= new_code;
            if (new_code == CODE_END) begin
               number  <= acc;
               num_err <= ovf;
               acc     <= '0;
               dcnt    <= '0;
               ovf     <= 1'b0;
            end else if (new_code == CODE_CLEAR) begin
               acc  <= '0;
               dcnt <= '0;
               ovf  <= 1'b0;
            end else if (is_digit(new_code) && !ovf) begin
               if (dig_ovf) ovf <= 1'b1;
               else begin
                  acc  <= prod[31:0];
                  dcnt <= dcnt_inc;
               end
            end
         end
      end
endmodule
